// File: rtl/board_ctrl_pkg.sv
// Shared types and helpers for the board control blocks: reset FSM states,
// a width helper and the default 48 MHz timing constants.
package board_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD,
    COUNT,
    RUN
  } rst_state_t;

  // Never returns less than 1, so a degenerate counter still has a legal width.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((longint'(1) << width) < longint'(value)) begin
      width = width + 1;
    end
    return width;
  endfunction

  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_48MHZ   = 65536;
  localparam int LONG_CYCLES_48MHZ       = 48000000;
  localparam int PROLONG_CYCLES_48MHZ    = 32768;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: polarity fix, synchroniser, debounce, registered
// press/release pulses and a once-per-press long-press pulse.
module btn_debounce_chan
  import board_ctrl_pkg::*;
#(
  parameter logic INVERT          = 1'b0,
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_48MHZ,
  parameter int   LONG_CYCLES     = LONG_CYCLES_48MHZ
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DW = clog2(DEBOUNCE_CYCLES);
  localparam int LW = clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LCNT_ARM  = LW'(LONG_CYCLES - 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DW-1:0]          dcnt;
  logic [LW-1:0]          lcnt;
  logic                   toggle;
  logic                   level_next;

  assign sync       = sync_q[SYNC_STAGES-1];
  assign toggle     = (sync != btn_level) && (dcnt == DCNT_LAST);
  assign level_next = btn_level ^ toggle;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw ^ INVERT};
    end
  end

  // Pulses are registered alongside the level so they share its first cycle.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      dcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      if ((sync == btn_level) || toggle) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      btn_level   <= level_next;
      btn_press   <= toggle & ~btn_level;
      btn_release <= toggle & btn_level;
    end
  end

  // Counter is held at 0 on the press and release cycles; a release due in
  // the same cycle as the long pulse wins because level_next is then 0.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      lcnt     <= '0;
      btn_long <= 1'b0;
    end else begin
      if (!btn_level || !level_next) begin
        lcnt <= '0;
      end else if (lcnt != LCNT_MAX) begin
        lcnt <= lcnt + 1'b1;
      end
      btn_long <= btn_level && level_next && (lcnt == LCNT_ARM);
    end
  end

endmodule

// File: rtl/btn_reset_conditioner.sv
// Board-level button conditioner and prolonged system reset generator driven
// by the synchronised PLL lock and an optional debounced reset button.
module btn_reset_conditioner
  import board_ctrl_pkg::*;
#(
  parameter int                 NUM_BTN         = 7,
  parameter logic [NUM_BTN-1:0] BTN_INVERT      = '0,
  parameter int                 SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int                 DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_48MHZ,
  parameter int                 LONG_CYCLES     = LONG_CYCLES_48MHZ,
  parameter int                 PROLONG_CYCLES  = PROLONG_CYCLES_48MHZ,
  parameter logic               RESET_BTN_EN    = 1'b1,
  parameter int                 RESET_BTN       = 1
) (
  input  logic               clk_48mhz,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic               sys_reset,
  output logic               reset_done
);

  localparam int PW = clog2(PROLONG_CYCLES);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PROLONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_q;
  logic                   lock_s;
  logic                   cause;
  rst_state_t             state;
  logic [PW-1:0]          pcnt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .INVERT          (BTN_INVERT[i]),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk_48mhz   (clk_48mhz),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      lock_q <= '0;
    end else begin
      lock_q <= {lock_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = lock_q[SYNC_STAGES-1];
  assign cause  = ~lock_s | (RESET_BTN_EN & btn_level[RESET_BTN]);

  // Any active cause restarts the whole prolong from HOLD.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      pcnt       <= '0;
      sys_reset  <= 1'b1;
      reset_done <= 1'b0;
    end else begin
      reset_done <= 1'b0;
      if (cause) begin
        state     <= HOLD;
        pcnt      <= '0;
        sys_reset <= 1'b1;
      end else begin
        case (state)
          HOLD: begin
            state <= COUNT;
          end
          COUNT: begin
            if (pcnt == PCNT_LAST) begin
              state      <= RUN;
              sys_reset  <= 1'b0;
              reset_done <= 1'b1;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          RUN: begin
            state <= RUN;
          end
          default: begin
            state     <= HOLD;
            sys_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_reset_conditioner.sv
// Self-checking bench: a sample-window model of the conditioner checked every
// cycle, plus hand-computed latencies for the directed scenarios.
module tb_btn_reset_conditioner;

  localparam int NB   = 3;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int PRO  = 8;
  localparam int RB   = 1;
  localparam int HD   = SYNC + DEB;
  localparam logic [NB-1:0] INV = 3'b010;

  localparam logic [NB-1:0] IDLE    = 3'b010;
  localparam logic [NB-1:0] PUSH_B0 = 3'b011;
  localparam logic [NB-1:0] PUSH_B1 = 3'b000;
  localparam logic [NB-1:0] PUSH_B2 = 3'b110;

  logic          clk_48mhz = 1'b0;
  logic          reset     = 1'b1;
  logic          pll_lock  = 1'b0;
  logic [NB-1:0] btn_raw   = IDLE;

  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;
  logic          sys_reset, reset_done;
  logic [NB-1:0] nb_level, nb_press, nb_release, nb_long;
  logic          nb_sys_reset, nb_reset_done;

  btn_reset_conditioner #(
    .NUM_BTN(NB), .BTN_INVERT(INV), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG), .PROLONG_CYCLES(PRO), .RESET_BTN_EN(1'b1), .RESET_BTN(RB)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .pll_lock(pll_lock), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .sys_reset(sys_reset), .reset_done(reset_done)
  );

  btn_reset_conditioner #(
    .NUM_BTN(NB), .BTN_INVERT(INV), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG), .PROLONG_CYCLES(PRO), .RESET_BTN_EN(1'b0), .RESET_BTN(RB)
  ) dut_noen (
    .clk_48mhz(clk_48mhz), .reset(reset), .pll_lock(pll_lock), .btn_raw(btn_raw),
    .btn_level(nb_level), .btn_press(nb_press), .btn_release(nb_release),
    .btn_long(nb_long), .sys_reset(nb_sys_reset), .reset_done(nb_reset_done)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_valid = 1'b0;

  // Model: a level flips once the last DEB synchronised samples all disagree
  // with it; sys_reset clears after PRO+1 consecutive cause-free samples.
  bit            m_hist [NB][HD];
  bit            m_lock [SYNC];
  bit            m_level[NB];
  int            m_age  [NB];
  int            quiet_en, quiet_no;
  logic [NB-1:0] exp_level, exp_press, exp_release, exp_long;
  logic          exp_sys_en, exp_done_en, exp_sys_no, exp_done_no;

  int press_cnt[NB], release_cnt[NB], long_cnt[NB];
  int last_press_cyc[NB], last_long_cyc[NB];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] raw, input logic lock);
    btn_raw  = raw;
    pll_lock = lock;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  initial begin
    bit lock_s, cause_en, cause_no, all_diff, old_l, new_l;
    forever begin
      @(posedge clk_48mhz or posedge reset);
      if (reset) begin
        cyc = 0;
        for (int c = 0; c < NB; c++) begin
          for (int j = 0; j < HD; j++) m_hist[c][j] = 1'b0;
          m_level[c] = 1'b0;
          m_age[c]   = 0;
        end
        for (int j = 0; j < SYNC; j++) m_lock[j] = 1'b0;
        quiet_en = 0; quiet_no = 0;
        exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
        exp_sys_en = 1'b1; exp_done_en = 1'b0; exp_sys_no = 1'b1; exp_done_no = 1'b0;
        model_valid = 1'b1;
      end else begin
        cyc++;
        lock_s   = m_lock[SYNC-1];
        cause_en = !lock_s || m_level[RB];
        cause_no = !lock_s;
        quiet_en = cause_en ? 0 : ((quiet_en < PRO + 2) ? quiet_en + 1 : quiet_en);
        quiet_no = cause_no ? 0 : ((quiet_no < PRO + 2) ? quiet_no + 1 : quiet_no);
        exp_sys_en  = (quiet_en <= PRO);
        exp_done_en = (quiet_en == PRO + 1);
        exp_sys_no  = (quiet_no <= PRO);
        exp_done_no = (quiet_no == PRO + 1);
        for (int c = 0; c < NB; c++) begin
          old_l    = m_level[c];
          all_diff = 1'b1;
          for (int j = SYNC - 1; j <= HD - 2; j++) begin
            if (m_hist[c][j] == old_l) all_diff = 1'b0;
          end
          new_l = all_diff ? !old_l : old_l;
          exp_press[c]   = new_l && !old_l;
          exp_release[c] = !new_l && old_l;
          if (new_l && !old_l)               m_age[c] = 0;
          else if (new_l && m_age[c] < LONG) m_age[c] = m_age[c] + 1;
          else if (!new_l)                   m_age[c] = 0;
          exp_long[c]  = new_l && old_l && (m_age[c] == LONG - 1);
          m_level[c]   = new_l;
          exp_level[c] = new_l;
          for (int j = HD - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
          m_hist[c][0] = btn_raw[c] ^ INV[c];
        end
        for (int j = SYNC - 1; j > 0; j--) m_lock[j] = m_lock[j-1];
        m_lock[0] = pll_lock;
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  initial begin
    for (int c = 0; c < NB; c++) begin
      press_cnt[c] = 0; release_cnt[c] = 0; long_cnt[c] = 0;
      last_press_cyc[c] = -1; last_long_cyc[c] = -1;
    end
    forever begin
      @(negedge clk_48mhz);
      if (model_valid) begin
        checkOutput("btn_level",   32'(btn_level),     32'(exp_level));
        checkOutput("btn_press",   32'(btn_press),     32'(exp_press));
        checkOutput("btn_release", 32'(btn_release),   32'(exp_release));
        checkOutput("btn_long",    32'(btn_long),      32'(exp_long));
        checkOutput("sys_reset",   32'(sys_reset),     32'(exp_sys_en));
        checkOutput("reset_done",  32'(reset_done),    32'(exp_done_en));
        checkOutput("noen_sys",    32'(nb_sys_reset),  32'(exp_sys_no));
        checkOutput("noen_done",   32'(nb_reset_done), 32'(exp_done_no));
        for (int c = 0; c < NB; c++) begin
          if (btn_press[c])   begin press_cnt[c]++; last_press_cyc[c] = cyc; end
          if (btn_release[c]) release_cnt[c]++;
          if (btn_long[c])    begin long_cnt[c]++; last_long_cyc[c] = cyc; end
        end
      end
    end
  end

  initial begin
    int k, k2, k3, sp, sr, sl;

    applyStimulus(IDLE, 1'b0);
    reset = 1'b1;
    tick(3);
    checkOutput("rst_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("rst_btn_level", 32'(btn_level), 32'd0);
    checkOutput("rst_reset_done", 32'(reset_done), 32'd0);
    reset = 1'b0;

    // Reset and lock: lock raised after cycle 10, release at cycle 21.
    tick(10);
    applyStimulus(IDLE, 1'b1);
    tick(10);
    checkOutput("lock_sys_c20", 32'(sys_reset), 32'd1);
    tick(1);
    checkOutput("lock_sys_c21", 32'(sys_reset), 32'd0);
    checkOutput("lock_done_c21", 32'(reset_done), 32'd1);
    checkOutput("noen_sys_c21", 32'(nb_sys_reset), 32'd0);
    tick(1);
    checkOutput("lock_done_c22", 32'(reset_done), 32'd0);

    // Bouncy press on button 0.
    sp = press_cnt[0];
    applyStimulus(PUSH_B0, 1'b1); tick(1);
    applyStimulus(IDLE, 1'b1);    tick(1);
    applyStimulus(PUSH_B0, 1'b1); tick(1);
    applyStimulus(IDLE, 1'b1);    tick(1);
    applyStimulus(PUSH_B0, 1'b1);
    k = cyc;
    tick(5);
    checkOutput("bounce_level_k5", 32'(btn_level[0]), 32'd0);
    checkOutput("bounce_nopress", 32'(press_cnt[0]), 32'(sp));
    tick(1);
    checkOutput("bounce_level_k6", 32'(btn_level[0]), 32'd1);
    checkOutput("bounce_press_k6", 32'(btn_press[0]), 32'd1);
    tick(1);
    checkOutput("bounce_press_k7", 32'(btn_press[0]), 32'd0);
    checkOutput("bounce_presscnt", 32'(press_cnt[0]), 32'(sp + 1));
    applyStimulus(IDLE, 1'b1);
    tick(12);

    // Long press on button 2.
    sp = press_cnt[2]; sr = release_cnt[2]; sl = long_cnt[2];
    applyStimulus(PUSH_B2, 1'b1);
    k = cyc;
    tick(40);
    applyStimulus(IDLE, 1'b1);
    tick(30);
    checkOutput("long_press_cyc", 32'(last_press_cyc[2]), 32'(k + 6));
    checkOutput("long_count", 32'(long_cnt[2]), 32'(sl + 1));
    checkOutput("long_delay", 32'(last_long_cyc[2] - last_press_cyc[2]), 32'd19);
    checkOutput("long_release", 32'(release_cnt[2]), 32'(sr + 1));

    // Short press on button 2.
    sp = press_cnt[2]; sr = release_cnt[2]; sl = long_cnt[2];
    applyStimulus(PUSH_B2, 1'b1);
    tick(10);
    applyStimulus(IDLE, 1'b1);
    tick(20);
    checkOutput("short_press", 32'(press_cnt[2]), 32'(sp + 1));
    checkOutput("short_release", 32'(release_cnt[2]), 32'(sr + 1));
    checkOutput("short_nolong", 32'(long_cnt[2]), 32'(sl));

    // Inverted button 1, which is also the reset button.
    checkOutput("inv_idle_level", 32'(btn_level[1]), 32'd0);
    applyStimulus(PUSH_B1, 1'b1);
    tick(6);
    checkOutput("inv_press", 32'(btn_press[1]), 32'd1);
    tick(1);
    checkOutput("btnrst_sys", 32'(sys_reset), 32'd1);
    checkOutput("btnrst_noen_sys", 32'(nb_sys_reset), 32'd0);

    // Release, then press again so the level returns while pcnt is 5.
    tick(4);
    applyStimulus(IDLE, 1'b1);
    k2 = cyc;
    tick(7);
    applyStimulus(PUSH_B1, 1'b1);
    tick(6);
    checkOutput("midcount_level", 32'(btn_level[1]), 32'd1);
    checkOutput("midcount_sys_k13", 32'(sys_reset), 32'd1);
    tick(2);
    checkOutput("midcount_sys_k15", 32'(sys_reset), 32'd1);
    checkOutput("midcount_noen", 32'(nb_sys_reset), 32'd0);
    tick(5);
    applyStimulus(IDLE, 1'b1);
    k3 = cyc;
    tick(14);
    checkOutput("reprolong_sys_k14", 32'(sys_reset), 32'd1);
    tick(1);
    checkOutput("reprolong_sys_k15", 32'(sys_reset), 32'd0);
    checkOutput("reprolong_done", 32'(reset_done), 32'd1);
    tick(5);

    // Lock loss: sys_reset rises three cycles after the pin drops.
    applyStimulus(IDLE, 1'b0);
    tick(2);
    checkOutput("lockloss_sys_k2", 32'(sys_reset), 32'd0);
    tick(1);
    checkOutput("lockloss_sys_k3", 32'(sys_reset), 32'd1);
    checkOutput("lockloss_noen_k3", 32'(nb_sys_reset), 32'd1);
    applyStimulus(IDLE, 1'b1);
    tick(15);

    // Reset asserted mid-press: channel restarts from level 0.
    applyStimulus(PUSH_B0, 1'b1);
    tick(8);
    reset = 1'b1;
    tick(2);
    checkOutput("midrst_level", 32'(btn_level[0]), 32'd0);
    reset = 1'b0;
    tick(5);
    checkOutput("midrst_level_c5", 32'(btn_level[0]), 32'd0);
    tick(1);
    checkOutput("midrst_level_c6", 32'(btn_level[0]), 32'd1);
    checkOutput("midrst_press_c6", 32'(btn_press[0]), 32'd1);
    applyStimulus(IDLE, 1'b1);
    tick(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
